// File: rtl/router_output_port.sv
// router_output_port: buffers words from the switch fabric in a small FIFO and
// serialises each one LSB first onto a 1-bit link with active-low valid/frame.
module router_output_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int GAP    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] fab_data,
  input  logic              fab_valid,
  input  logic              out_stall,
  output logic              dout,
  output logic              valido_n,
  output logic              frameo_n,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;

  // serialiser state
  state_t            r_state;
  logic [DATA_W-1:0] r_sr;
  logic [BW-1:0]     r_bc;
  logic [3:0]        r_gc;

  // registered outputs
  logic              r_dout;
  logic              r_valido_n;
  logic              r_frameo_n;
  logic              r_busy;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  // next-state values
  logic [AW-1:0]     w_wp_nx;
  logic [AW-1:0]     w_rp_nx;
  logic [CW-1:0]     w_cnt_nx;
  state_t            w_state_nx;
  logic [DATA_W-1:0] w_sr_nx;
  logic [BW-1:0]     w_bc_nx;
  logic [3:0]        w_gc_nx;
  logic              w_dout_nx;
  logic              w_valido_n_nx;
  logic              w_frameo_n_nx;
  logic              w_busy_nx;
  logic              w_overflow_nx;
  logic [7:0]        w_drop_cnt_nx;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [DATA_W-1:0] w_head;
  logic [BW-1:0]     w_bc_inc;
  logic              w_gap_done;

  assign w_full     = (r_cnt == FULL_CNT);
  assign w_empty    = (r_cnt == '0);
  assign w_head     = r_mem[r_rp];
  assign w_bc_inc   = r_bc + BW'(1);
  assign w_gap_done = (({1'b0, r_gc} + 5'd1) >= 5'(GAP));

  // Only IDLE pops, so a full FIFO accepts a push exactly on an IDLE pop edge.
  assign w_pop  = (r_state == S_IDLE) && !w_empty;
  assign w_push = fab_valid && (!w_full || w_pop);
  assign w_drop = fab_valid && w_full && !w_pop;

  always_comb begin
    w_wp_nx       = r_wp;
    w_rp_nx       = r_rp;
    w_cnt_nx      = r_cnt;
    w_state_nx    = r_state;
    w_sr_nx       = r_sr;
    w_bc_nx       = r_bc;
    w_gc_nx       = r_gc;
    w_dout_nx     = r_dout;
    w_valido_n_nx = 1'b1;
    w_frameo_n_nx = 1'b1;
    w_overflow_nx = r_overflow | w_drop;
    w_drop_cnt_nx = r_drop_cnt;

    if (w_drop && (r_drop_cnt != 8'hFF)) begin
      w_drop_cnt_nx = r_drop_cnt + 8'd1;
    end

    if (w_push) begin
      w_wp_nx = r_wp + AW'(1);
    end
    if (w_pop) begin
      w_rp_nx = r_rp + AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   w_cnt_nx = r_cnt + CW'(1);
      2'b01:   w_cnt_nx = r_cnt - CW'(1);
      default: w_cnt_nx = r_cnt;
    endcase

    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_sr_nx       = w_head;
          w_bc_nx       = '0;
          w_dout_nx     = w_head[0];
          w_valido_n_nx = 1'b0;
          w_frameo_n_nx = (LAST_BIT == '0);
          w_state_nx    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (out_stall) begin
          // dout and bc already hold; keep the frame marker where it was
          w_frameo_n_nx = r_frameo_n;
        end else if (r_bc == LAST_BIT) begin
          w_gc_nx    = '0;
          w_state_nx = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          w_bc_nx       = w_bc_inc;
          w_dout_nx     = r_sr[w_bc_inc];
          w_valido_n_nx = 1'b0;
          w_frameo_n_nx = (w_bc_inc == LAST_BIT);
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          w_state_nx = S_IDLE;
        end else begin
          w_gc_nx = r_gc + 4'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    w_busy_nx = (w_cnt_nx != '0) || (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_bc       <= '0;
      r_gc       <= '0;
      r_dout     <= 1'b0;
      r_valido_n <= 1'b1;
      r_frameo_n <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wp       <= w_wp_nx;
      r_rp       <= w_rp_nx;
      r_cnt      <= w_cnt_nx;
      r_state    <= w_state_nx;
      r_sr       <= w_sr_nx;
      r_bc       <= w_bc_nx;
      r_gc       <= w_gc_nx;
      r_dout     <= w_dout_nx;
      r_valido_n <= w_valido_n_nx;
      r_frameo_n <= w_frameo_n_nx;
      r_busy     <= w_busy_nx;
      r_overflow <= w_overflow_nx;
      r_drop_cnt <= w_drop_cnt_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wp] <= fab_data;
    end
  end

  assign dout     = r_dout;
  assign valido_n = r_valido_n;
  assign frameo_n = r_frameo_n;
  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_router_output_port.sv
// Directed bench for router_output_port: a monitor deserialises frames and
// checks them against a queue of words expected to survive the FIFO.
module tb_router_output_port;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int GAP   = 1;
  localparam int PER   = DW + GAP + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] fab_data = '0;
  logic          fab_valid = 1'b0;
  logic          out_stall = 1'b0;
  logic          dout;
  logic          valido_n;
  logic          frameo_n;
  logic          busy;
  logic          overflow;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb [$];
  int            fstart [$];
  int            flen [$];
  int            cyc = 0;
  int            frames = 0;
  int            bitcnt = 0;
  int            cur_start = 0;
  logic [DW-1:0] shreg = '0;

  router_output_port #(
    .DATA_W(DW),
    .DEPTH (DEPTH),
    .GAP   (GAP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .fab_data (fab_data),
    .fab_valid(fab_valid),
    .out_stall(out_stall),
    .dout     (dout),
    .valido_n (valido_n),
    .frameo_n (frameo_n),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: collects valid bits LSB first, checks framing and payload.
  always @(negedge clock) begin
    if (reset) begin
      bitcnt = 0;
    end else if (!valido_n) begin
      if (bitcnt == 0) cur_start = cyc;
      shreg[bitcnt] = dout;
      chk("frameo_n_bit", {31'd0, frameo_n}, {31'd0, (bitcnt == DW - 1)});
      if (bitcnt == DW - 1) begin
        fstart.push_back(cur_start);
        flen.push_back(cyc - cur_start + 1);
        chk("frame_expected", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) chk("frame_data", shreg, sb.pop_front());
        frames++;
        bitcnt = 0;
      end else begin
        bitcnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    while (frames < n && budget > 0) begin
      tick();
      budget--;
    end
    chk("frame_count", frames, n);
  endtask

  task automatic wait_bit(input int b, input int budget);
    while (!(bitcnt == b && !valido_n) && budget > 0) begin
      tick();
      budget--;
    end
    chk("bit_reached", bitcnt, b);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_dout", {31'd0, dout}, 32'd0);
    chk("rst_valido_n", {31'd0, valido_n}, 32'd1);
    chk("rst_frameo_n", {31'd0, frameo_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    reset = 1'b0;
    tick();

    // single word, latency k+2
    fab_valid = 1'b1;
    fab_data  = 32'hA5A5_0001;
    sb.push_back(32'hA5A5_0001);
    tick();
    fab_valid = 1'b0;
    chk("lat_k1_valido_n", {31'd0, valido_n}, 32'd1);
    tick();
    chk("lat_k2_valido_n", {31'd0, valido_n}, 32'd0);
    chk("lat_k2_dout", {31'd0, dout}, 32'd1);
    chk("lat_k2_frameo_n", {31'd0, frameo_n}, 32'd0);
    wait_frames(1, 100);
    chk("t1_len", flen[0], DW);
    tick();
    chk("t1_gap_valido_n", {31'd0, valido_n}, 32'd1);
    chk("t1_gap_frameo_n", {31'd0, frameo_n}, 32'd1);
    tick();
    tick();

    // three back-to-back words
    for (int i = 1; i <= 3; i++) begin
      fab_valid = 1'b1;
      fab_data  = DW'(i);
      sb.push_back(DW'(i));
      tick();
    end
    fab_valid = 1'b0;
    wait_frames(4, 3 * PER + 50);
    chk("t2_spacing_a", fstart[2] - fstart[1], PER);
    chk("t2_spacing_b", fstart[3] - fstart[2], PER);
    tick();
    tick();
    tick();
    chk("t2_busy_low", {31'd0, busy}, 32'd0);

    // ten consecutive pushes, one dropped
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("t3_no_early_ovf", {31'd0, overflow}, 32'd0);
      fab_valid = 1'b1;
      fab_data  = 32'h3000_0000 + DW'(i);
      if (i < 9) sb.push_back(32'h3000_0000 + DW'(i));
      tick();
    end
    fab_valid = 1'b0;
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    wait_frames(13, 9 * PER + 50);

    // stall five cycles at bit 10
    tick();
    tick();
    tick();
    fab_valid = 1'b1;
    fab_data  = 32'hFFFF_0000;
    sb.push_back(32'hFFFF_0000);
    tick();
    fab_valid = 1'b0;
    wait_bit(11, 100);
    chk("t4_bit10", {31'd0, dout}, 32'd0);
    out_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) out_stall = 1'b0;
      chk("t4_stall_valido_n", {31'd0, valido_n}, 32'd1);
      chk("t4_stall_dout", {31'd0, dout}, 32'd0);
      chk("t4_stall_frameo_n", {31'd0, frameo_n}, 32'd0);
    end
    tick();
    chk("t4_resume_valido_n", {31'd0, valido_n}, 32'd0);
    chk("t4_resume_bitcnt", bitcnt, 12);
    wait_frames(14, 100);
    chk("t4_len", flen[13], DW + 5);
    tick();
    tick();
    tick();

    // reset mid-frame with two words queued
    for (int i = 0; i < 3; i++) begin
      fab_valid = 1'b1;
      fab_data  = 32'h7700_0000 + DW'(i);
      sb.push_back(32'h7700_0000 + DW'(i));
      tick();
    end
    fab_valid = 1'b0;
    wait_bit(17, 100);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t5_valido_n", {31'd0, valido_n}, 32'd1);
    chk("t5_frameo_n", {31'd0, frameo_n}, 32'd1);
    chk("t5_dout", {31'd0, dout}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    chk("t5_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    fab_valid = 1'b1;
    fab_data  = 32'h0000_0000;
    sb.push_back(32'h0000_0000);
    tick();
    fab_data = 32'hC3C3_0F0F;
    sb.push_back(32'hC3C3_0F0F);
    tick();
    fab_valid = 1'b0;
    chk("t5_lat_valido_n", {31'd0, valido_n}, 32'd0);
    chk("t5_lat_dout", {31'd0, dout}, 32'd0);
    chk("t5_lat_bitcnt", bitcnt, 1);
    wait_frames(16, 2 * PER + 50);
    tick();
    tick();
    tick();

    // drop saturation while the serialiser is stalled
    fab_valid = 1'b1;
    fab_data  = 32'h5A5A_A5A5;
    sb.push_back(32'h5A5A_A5A5);
    tick();
    fab_valid = 1'b0;
    wait_bit(3, 100);
    out_stall = 1'b1;
    for (int i = 0; i < 308; i++) begin
      fab_valid = 1'b1;
      fab_data  = 32'h6000_0000 + DW'(i);
      if (i < DEPTH) sb.push_back(32'h6000_0000 + DW'(i));
      tick();
      if (i == DEPTH - 1) chk("t6_no_drop_yet", {31'd0, overflow}, 32'd0);
      if (i == 107) chk("t6_drop_100", {24'd0, drop_cnt}, 32'd100);
      if (i == 261) chk("t6_drop_254", {24'd0, drop_cnt}, 32'd254);
    end
    fab_valid = 1'b0;
    chk("t6_drop_sat", {24'd0, drop_cnt}, 32'd255);
    chk("t6_overflow", {31'd0, overflow}, 32'd1);
    chk("t6_stall_valido_n", {31'd0, valido_n}, 32'd1);
    out_stall = 1'b0;
    wait_frames(25, 9 * PER + 100);
    tick();
    tick();
    tick();
    chk("t6_drop_hold", {24'd0, drop_cnt}, 32'd255);
    chk("t6_overflow_hold", {31'd0, overflow}, 32'd1);
    chk("t6_busy_low", {31'd0, busy}, 32'd0);
    chk("t6_sb_empty", sb.size(), 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
